// File: rtl/mod_accumulator.sv
// Registered modular accumulator: each enabled cycle acc <= (acc + iData) reduced by one
// conditional subtraction of iQ; iQ == 0 selects plain 2^BITWIDTH wraparound.
module mod_accumulator #(
    parameter int BITWIDTH = 32
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iEn,
    input  logic                iClr,
    input  logic [BITWIDTH-1:0] iData,
    input  logic [BITWIDTH-1:0] iQ,
    output logic [BITWIDTH-1:0] oData
);

    logic [BITWIDTH-1:0] acc_q;
    logic [BITWIDTH-1:0] acc_d;

    // The sum keeps its carry bit so the compare against q never loses overflow;
    // the subtraction can be done at BITWIDTH because the result is truncated anyway.
    function automatic logic [BITWIDTH-1:0] modadd(
        input logic [BITWIDTH-1:0] a,
        input logic [BITWIDTH-1:0] d,
        input logic [BITWIDTH-1:0] q
    );
        logic [BITWIDTH:0] s;
        s = {1'b0, a} + {1'b0, d};
        if ((q != '0) && (s >= {1'b0, q})) begin
            modadd = s[BITWIDTH-1:0] - q;
        end else begin
            modadd = s[BITWIDTH-1:0];
        end
    endfunction

    always_comb begin
        acc_d = acc_q;
        if (iClr) begin
            acc_d = '0;
        end else if (iEn) begin
            acc_d = modadd(acc_q, iData, iQ);
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign oData = acc_q;

endmodule

// File: tb/tb_mod_accumulator.sv
// Bench for mod_accumulator: directed vector table followed by randomized traffic
// compared against an arithmetic reference model.
module tb_mod_accumulator;

    localparam int BW = 32;

    logic          clk;
    logic          rstn;
    logic          en;
    logic          clr;
    logic [BW-1:0] data;
    logic [BW-1:0] q;
    logic [BW-1:0] dout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          rstn;
        logic          en;
        logic          clr;
        logic [BW-1:0] d;
        logic [BW-1:0] q;
        logic [BW-1:0] exp;
        string         name;
    } vec_t;

    vec_t tbl[$];

    mod_accumulator #(.BITWIDTH(BW)) dut (
        .iClk (clk),
        .iRstN(rstn),
        .iEn  (en),
        .iClr (clr),
        .iData(data),
        .iQ   (q),
        .oData(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic c,
                       input logic [BW-1:0] d, input logic [BW-1:0] qq,
                       input logic [BW-1:0] x, input string nm);
        vec_t v;
        v.rstn = r; v.en = e; v.clr = c; v.d = d; v.q = qq; v.exp = x; v.name = nm;
        tbl.push_back(v);
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic e, input logic c,
                        input logic [BW-1:0] d, input logic [BW-1:0] qq);
        @(negedge clk);
        rstn = r; en = e; clr = c; data = d; q = qq;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [BW-1:0] exp);
        checks++;
        if (dout !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, dout, exp);
        end
    endtask

    // Reference: plain unbounded arithmetic, then the single-subtraction rule.
    function automatic logic [BW-1:0] ref_next(input logic [BW-1:0] acc, input logic r,
                                               input logic e, input logic c,
                                               input logic [BW-1:0] d, input logic [BW-1:0] qq);
        longint unsigned s;
        if (!r || c) return '0;
        if (!e) return acc;
        s = longint'(acc) + longint'(d);
        if (qq == 0) return BW'(s % (64'd1 << BW));
        if (s >= longint'(qq)) s = s - longint'(qq);
        return BW'(s);
    endfunction

    initial begin
        int unsigned seq13[13];
        logic [BW-1:0] model;
        rstn = 1'b0; en = 1'b0; clr = 1'b0; data = '0; q = '0;

        seq13 = '{10, 7, 4, 1, 11, 8, 5, 2, 12, 9, 6, 3, 0};

        add(1'b0, 1'b1, 1'b0, 10, 13, 0, "reset");
        foreach (seq13[i]) add(1'b1, 1'b1, 1'b0, 10, 13, seq13[i], "run13");
        add(1'b1, 1'b1, 1'b0, 10, 13, 10, "run13_wrap");
        add(1'b1, 1'b1, 1'b1, 10, 13, 0, "clr_with_en");
        add(1'b1, 1'b1, 1'b1, 10, 13, 0, "clr_held");
        add(1'b1, 1'b1, 1'b0, 10, 13, 10, "after_clr0");
        add(1'b1, 1'b1, 1'b0, 10, 13, 7, "after_clr1");
        for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 1'b0, 10, 13, 7, "hold");
        add(1'b1, 1'b1, 1'b0, 10, 13, 4, "resume");
        for (int i = 3; i < 13; i++) add(1'b1, 1'b1, 1'b0, 10, 13, seq13[i], "run_to_exact");
        add(1'b1, 1'b1, 1'b0, 12, 13, 12, "q_minus_1");
        add(1'b1, 1'b0, 1'b1, 0, 13, 0, "clr_no_en");
        add(1'b1, 1'b1, 1'b0, 32'hFFFFFFFA, 0, 32'hFFFFFFFA, "load_wide");
        add(1'b1, 1'b1, 1'b0, 32'hFFFFFFFA, 32'hFFFFFFFB, 32'hFFFFFFF9, "wide_carry");
        add(1'b1, 1'b1, 1'b0, 6, 0, 32'hFFFFFFFF, "q0_fill");
        add(1'b1, 1'b1, 1'b0, 2, 0, 1, "q0_wrap");
        add(1'b1, 1'b1, 1'b0, 10, 13, 11, "reseed");
        add(1'b0, 1'b1, 1'b0, 10, 13, 0, "mid_reset");
        add(1'b1, 1'b1, 1'b0, 10, 13, 10, "post_reset0");
        add(1'b1, 1'b1, 1'b0, 10, 13, 7, "post_reset1");

        foreach (tbl[i]) begin
            step(tbl[i].rstn, tbl[i].en, tbl[i].clr, tbl[i].d, tbl[i].q);
            check(tbl[i].name, tbl[i].exp);
        end

        // Hand sequence: holding reset keeps output at 0 regardless of enable/data.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h1234, 32'h5000);
            check("reset_held", 0);
        end
        model = '0;

        for (int n = 0; n < 600; n++) begin
            logic          r, e, c;
            logic [BW-1:0] d, qq;
            int unsigned   pick;
            pick = $urandom_range(0, 99);
            r  = (pick != 0);
            c  = ($urandom_range(0, 49) == 0);
            e  = ($urandom_range(0, 3) != 0);
            pick = $urandom_range(0, 9);
            if (pick == 0)      qq = 0;
            else if (pick < 4)  qq = BW'($urandom_range(1, 50));
            else                qq = $urandom;
            pick = $urandom_range(0, 9);
            if (pick == 0 || qq == 0) d = $urandom;
            else                      d = $urandom % qq;
            model = ref_next(model, r, e, c, d, qq);
            step(r, e, c, d, qq);
            check("random", model);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
